// File: rtl/snake_pkg.sv
// Shared snake-game types: board geometry, coordinate/pixel-map types and
// the apple spawner state encoding.
package snake_pkg;

    localparam int BOARD_DIM = 16;

    typedef logic [3:0]        coord_t;
    typedef logic [15:0][15:0] pixmap_t;   // indexed [x][y]

    typedef enum logic [1:0] {
        SEARCH,
        SCAN,
        PLACED,
        FULL
    } spawn_state_t;

    // Single-cell map with bit [x][y] set
    function automatic pixmap_t cell_onehot(input coord_t x, input coord_t y);
        pixmap_t m;
        m       = '0;
        m[x][y] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR (taps 7,5,4,3), period 255. Holds while enable is low.
module lfsr8 (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    // Load seed on reset (all-zero would lock up, so it maps to 1); step when enabled
    always_ff @(posedge clk) begin
        if (reset)
            q <= (seed == 8'h00) ? 8'h01 : seed;
        else if (enable)
            q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    end

endmodule

// File: rtl/apple_spawner.sv
// Apple spawner: places one apple on a free board cell using random LFSR
// candidates, falling back to a linear scan after MAX_TRIES misses, and
// flags boardFull when no free cell exists.
// Optional build macro: FIXED_FIRST_APPLE_EN -- the first search after reset
// tries (APPLE_X0, APPLE_Y0) before any random candidate.
module apple_spawner
    import snake_pkg::*;
#(
    parameter logic [7:0] SEED      = 8'hA5,
    parameter int         MAX_TRIES = 16,
    parameter coord_t     APPLE_X0  = 4'd12,
    parameter coord_t     APPLE_Y0  = 4'd8
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    enable,
    input  logic    eaten,
    input  pixmap_t snakePixels,
    output pixmap_t RedPixels,
    output coord_t  appleX,
    output coord_t  appleY,
    output logic    appleValid,
    output logic    boardFull
);

    spawn_state_t state;
    logic [7:0]   lfsr;
    logic [7:0]   tries;
    logic [7:0]   scan_idx;
    logic [7:0]   scan_cnt;
    coord_t       cx, cy;
    logic         cand_free;
    logic         fixed_try;

    lfsr8 u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .seed   (SEED),
        .q      (lfsr)
    );

`ifdef FIXED_FIRST_APPLE_EN
    logic first;

    // Armed by reset; consumed by the first enabled SEARCH cycle whatever its outcome
    always_ff @(posedge clk) begin
        if (reset)
            first <= 1'b1;
        else if (enable && state == SEARCH)
            first <= 1'b0;
    end

    assign fixed_try = first;
`else
    assign fixed_try = 1'b0;
`endif

    // Candidate cell for this cycle: scan pointer, fixed first cell, or LFSR
    always_comb begin
        cx = lfsr[7:4];
        cy = lfsr[3:0];
        if (state == SCAN) begin
            cx = scan_idx[7:4];
            cy = scan_idx[3:0];
        end else if (fixed_try) begin
            cx = APPLE_X0;
            cy = APPLE_Y0;
        end
        cand_free = ~snakePixels[cx][cy];
    end

    // Spawner FSM with registered apple outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SEARCH;
            RedPixels  <= '0;
            appleX     <= '0;
            appleY     <= '0;
            appleValid <= 1'b0;
            boardFull  <= 1'b0;
            tries      <= '0;
            scan_idx   <= '0;
            scan_cnt   <= '0;
        end else if (enable) begin
            case (state)
                SEARCH: begin
                    if (cand_free) begin
                        appleX     <= cx;
                        appleY     <= cy;
                        RedPixels  <= cell_onehot(cx, cy);
                        appleValid <= 1'b1;
                        state      <= PLACED;
                    end else if (!fixed_try) begin
                        // the fixed first cell is a bonus probe, not a counted try
                        tries <= tries + 8'd1;
                        if (tries == 8'(MAX_TRIES - 1)) begin
                            scan_idx <= {cx, cy};
                            scan_cnt <= '0;
                            state    <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (cand_free) begin
                        appleX     <= cx;
                        appleY     <= cy;
                        RedPixels  <= cell_onehot(cx, cy);
                        appleValid <= 1'b1;
                        state      <= PLACED;
                    end else if (scan_cnt == 8'hFF) begin
                        // every cell visited once and all occupied
                        boardFull <= 1'b1;
                        RedPixels <= '0;
                        state     <= FULL;
                    end else begin
                        scan_idx <= scan_idx + 8'd1;
                        scan_cnt <= scan_cnt + 8'd1;
                    end
                end
                PLACED: begin
                    if (eaten) begin
                        RedPixels  <= '0;
                        appleValid <= 1'b0;
                        tries      <= '0;
                        state      <= SEARCH;
                    end
                end
                FULL: begin
                    RedPixels <= '0;
                end
                default: state <= SEARCH;
            endcase
        end
    end

endmodule

// File: tb/tb_apple_spawner.sv
// Randomized self-checking bench for apple_spawner. The reference model walks
// the LFSR candidate sequence and linear-scan fallback arithmetically to
// predict where and after how many cycles the apple appears.
module tb_apple_spawner;
    import snake_pkg::*;

    localparam logic [7:0] SEED = 8'hA5;
    localparam int         MT   = 4;
`ifdef FIXED_FIRST_APPLE_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic    clk = 1'b0;
    logic    reset, enable, eaten;
    pixmap_t snake, red;
    coord_t  ax, ay;
    logic    av, bf;

    int tests = 0;
    int fails = 0;
    logic [7:0] mlfsr;

    apple_spawner #(.SEED(SEED), .MAX_TRIES(MT), .APPLE_X0(4'd12), .APPLE_Y0(4'd8)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .eaten       (eaten),
        .snakePixels (snake),
        .RedPixels   (red),
        .appleX      (ax),
        .appleY      (ay),
        .appleValid  (av),
        .boardFull   (bf)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], ^(l & 8'hB8)};
    endfunction

    function automatic pixmap_t cell_map(input int x, input int y);
        pixmap_t m;
        m = '0;
        m[x][y] = 1'b1;
        return m;
    endfunction

    // One clock; the model LFSR follows the reset/enable rules
    task automatic tick();
        @(posedge clk);
        if (reset)       mlfsr = SEED;
        else if (enable) mlfsr = lfsr_step(mlfsr);
        #1;
    endtask

    // Predict placement cell and cycle count for a search starting now
    task automatic predict(input logic [7:0] l0, input pixmap_t s, input bit first,
                           output int lat, output int px, output int py, output bit full);
        logic [7:0] l;
        logic [7:0] idx;
        int tries;
        l = l0; lat = 0; tries = 0; full = 0; px = 0; py = 0;
        if (FIXED && first) begin
            lat = 1;
            if (!s[12][8]) begin px = 12; py = 8; return; end
            l = lfsr_step(l);
        end
        while (1) begin
            lat++;
            if (!s[l[7:4]][l[3:0]]) begin px = l[7:4]; py = l[3:0]; return; end
            tries++;
            if (tries == MT) break;
            l = lfsr_step(l);
        end
        for (int k = 0; k < 256; k++) begin
            lat++;
            idx = l + 8'(k);
            if (!s[idx[7:4]][idx[3:0]]) begin px = idx[7:4]; py = idx[3:0]; return; end
        end
        full = 1;
    endtask

    task automatic run_search(input bit first, output int px, output int py);
        int lat; bit full;
        predict(mlfsr, snake, first, lat, px, py, full);
        for (int i = 0; i < lat - 1; i++) tick();
        check("pre_valid", av, 0);
        check("pre_full", bf, 0);
        tick();
        if (full) begin
            check("full_flag", bf, 1);
            check("full_red", red, 0);
            check("full_valid", av, 0);
        end else begin
            check("valid", av, 1);
            check("apple_x", ax, px);
            check("apple_y", ay, py);
            check("red_map", red, cell_map(px, py));
            check("not_full", bf, 0);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int px, py, mode, dens;
        reset = 1'b1; enable = 1'b1; eaten = 1'b0; snake = '0;
        tick(); tick();
        check("rst_valid", av, 0);
        check("rst_full", bf, 0);
        check("rst_red", red, 0);
        check("rst_x", ax, 0);
        check("rst_y", ay, 0);

        // empty board: first candidate placed one cycle after reset release
        reset = 1'b0;
        run_search(1, px, py);
        check("first_x", ax, FIXED ? 12 : 10);
        check("first_y", ay, FIXED ? 8 : 5);

        // random eat/respawn trials
        for (int t = 0; t < 14; t++) begin
            // snake sliding over the apple must not move it
            snake = '1;
            tick(); tick();
            check("hold_valid", av, 1);
            check("hold_x", ax, px);
            check("hold_y", ay, py);
            eaten = 1'b1;
            tick();
            eaten = 1'b0;
            check("eat_valid", av, 0);
            check("eat_red", red, 0);
            mode = $urandom_range(0, 3);
            dens = (mode == 1) ? 50 : 95;
            if (mode == 0) snake = '0;
            else begin
                for (int x = 0; x < 16; x++)
                    for (int y = 0; y < 16; y++)
                        snake[x][y] = (mode == 3) || ($urandom_range(0, 99) < dens);
                snake[$urandom_range(0, 15)][$urandom_range(0, 15)] = 1'b0;
            end
            run_search(0, px, py);
        end

        // seed cell occupied: next LFSR candidate wins
        snake = '0; snake[10][5] = 1'b1;
        do_reset();
        run_search(1, px, py);

        // only (3,7) free: reached through the scan fallback
        snake = '1; snake[3][7] = 1'b0;
        do_reset();
        run_search(1, px, py);
        check("scan_x", ax, 3);
        check("scan_y", ay, 7);

        // board full: flag after MAX_TRIES+256 cycles, eaten ignored, reset clears
        snake = '1;
        do_reset();
        run_search(1, px, py);
        eaten = 1'b1;
        tick();
        eaten = 1'b0;
        tick();
        check("full_eaten_flag", bf, 1);
        check("full_eaten_valid", av, 0);
        check("full_eaten_red", red, 0);
        reset = 1'b1;
        tick();
        check("full_reset", bf, 0);

        // reset mid-scan, then hold enable low: outputs and LFSR frozen
        reset = 1'b0;
        for (int i = 0; i < MT + 10; i++) tick();
        reset = 1'b1; enable = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("frz_valid", av, 0);
        check("frz_full", bf, 0);
        check("frz_red", red, 0);
        check("frz_x", ax, 0);
        check("frz_y", ay, 0);
        snake = '0; enable = 1'b1;
        run_search(1, px, py);
        check("frz_first_x", ax, FIXED ? 12 : 10);
        check("frz_first_y", ay, FIXED ? 8 : 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/apple_spawner.md
Name: apple_spawner

Overview:
- Upstream producer of the `RedPixels` apple map that the apple-eaten detector consumes.
- Places exactly one apple on the 16x16 board, on a cell not occupied by the snake, using a free-running 8-bit LFSR.
- Clears the apple and respawns a new one when the detector reports it eaten (`eaten` = the detector's `win` pulse).
- Fallback linear scan guarantees a bounded-latency placement; signals board-full when no cell is free.

Parameters:
- `SEED`, 8'hA5: LFSR reset value. 8'h00 is illegal and is replaced by 8'h01.
- `MAX_TRIES`, 16: random candidates tested before falling back to linear scan. Range 1..255.
- `APPLE_X0`, 4'd12: first-apple X, used only with `FIXED_FIRST_APPLE_EN`.
- `APPLE_Y0`, 4'd8: first-apple Y, used only with `FIXED_FIRST_APPLE_EN`.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `enable` in 1: when 0, FSM, LFSR and all counters hold; outputs are held.
- `eaten` in 1: one-cycle pulse from the apple-eaten detector.
- `snakePixels` in [15:0][15:0]: snake occupancy map, indexed [x][y]; 1 = occupied.
- `RedPixels` out [15:0][15:0]: apple map, indexed [x][y]; one-hot or all-zero.
- `appleX` out 4: current apple X.
- `appleY` out 4: current apple Y.
- `appleValid` out 1: apple currently on board.
- `boardFull` out 1: no free cell found; sticky until reset.

Behaviour:
- Reset state (next edge with `reset`=1): `RedPixels`=0, `appleX`=0, `appleY`=0, `appleValid`=0, `boardFull`=0, `lfsr`=`SEED`, `tries`=0, state=SEARCH.
- Reset mid-operation aborts any search or scan and clears the apple.
- LFSR: Fibonacci, shift left, `lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}`. Period 255. Advances every enabled cycle in every state.
- Candidate cell: x = `lfsr[7:4]`, y = `lfsr[3:0]`. The first candidate after reset is `SEED` itself.
- SEARCH (one candidate per enabled cycle):
  - Candidate free (`snakePixels[x][y]`==0): on the same edge load `appleX`/`appleY`, set `RedPixels[x][y]`=1 (all other bits 0) and `appleValid`=1; go to PLACED.
  - Candidate occupied: `tries`++. When `tries` reaches `MAX_TRIES`, go to SCAN with `scanIdx` = {x,y} of the failing candidate and `scanCnt`=0.
- SCAN (one cell per cycle; cell x = `scanIdx[7:4]`, y = `scanIdx[3:0]`):
  - Cell free: place the apple exactly as in SEARCH; go to PLACED.
  - Cell occupied: `scanIdx`++ (wraps 255 to 0), `scanCnt`++.
  - When `scanCnt` reaches 255 with the cell still occupied (all 256 cells checked): `boardFull`=1, go to FULL.
- PLACED:
  - Hold outputs.
  - `eaten`=1: next edge `RedPixels`=0, `appleValid`=0, `tries`=0; go to SEARCH. A new apple appears no earlier than 2 cycles after `eaten`.
  - `eaten` in any other state is ignored.
- FULL: terminal state. Outputs held, `RedPixels`=0. Exit only by reset.
- Worst-case latency from entering SEARCH to `appleValid`: `MAX_TRIES`+256 enabled cycles.
- `snakePixels` is sampled combinationally each cycle. The snake moving onto a placed apple does not move it; the detector handles that case.
- Simultaneous `eaten` and `enable`=0: the pulse is lost. Upstream must assert `eaten` only while `enable`=1.
- Invariant: `RedPixels` has at most one bit set, and it equals bit [`appleX`][`appleY`] whenever `appleValid`=1.

Optional Feature:
- Macro `FIXED_FIRST_APPLE_EN`.
- Defined: the first SEARCH after reset tests (`APPLE_X0`, `APPLE_Y0`) before any LFSR candidate. If that cell is free, the apple is placed there on the first enabled cycle. If occupied, normal LFSR search follows. The LFSR still advances that cycle.
- Undefined: the first candidate comes from the LFSR as normal.

Decomposition:
- Shared package `snake_pkg`:
  - `BOARD_DIM`=16.
  - `typedef logic [3:0] coord_t`.
  - `typedef logic [15:0][15:0] pixmap_t`.
  - Spawner FSM enum `spawn_state_t` {SEARCH, SCAN, PLACED, FULL}.
- One sub-module: `lfsr8` (clk, reset, enable, seed, q), reusable by other randomised blocks.

Test Plan:
- Empty board, `SEED`=8'hA5, `enable`=1, release reset → 1 cycle later `appleX`=10, `appleY`=5, `RedPixels[10][5]`=1, `appleValid`=1.
- Apple placed, pulse `eaten` 1 cycle → next cycle `RedPixels`=0 and `appleValid`=0; new apple at a cell with `snakePixels`=0 within `MAX_TRIES`+256 cycles.
- `snakePixels[10][5]`=1, `SEED`=8'hA5 → cell (10,5) never gets an apple; first placement is the next free LFSR candidate, 2 cycles after reset.
- `snakePixels` all ones except cell (3,7), `MAX_TRIES`=4 → SCAN entered after 4 cycles; apple at (3,7); `boardFull`=0.
- `snakePixels` all ones → `boardFull`=1 after exactly `MAX_TRIES`+256 cycles; `RedPixels`=0; `eaten` ignored; reset clears `boardFull`.
- Assert `reset` mid-SCAN and hold `enable`=0 for 5 cycles → outputs at reset values and LFSR frozen at `SEED`; `FIXED_FIRST_APPLE_EN` run places (12,8) first cycle.
